core_sequencer: RTL
===================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer for the RV32IM datapath. Steps each instruction through FETCH, EXEC, WB.
//  Starts the ALU and waits for its ready, which covers multi-cycle MUL/DIV.
//  Gates register-file writes and the PC update. Supports free-run, single-step and an ALU-hang timeout.
//  Sits between ControlLogic/ALU/BranchControl and ProgramCounter/RegisterFile.
// PARAMETERS
//  ALU_TIMEOUT  40  max EXEC cycles allowed for alu_ready before fault (>=2)
//  CNT_W        6   width of EXEC cycle counter; must hold ALU_TIMEOUT
// PORTS
//  clk             in   1   system clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  run             in   1   1 = free-run instructions back to back
//  step_req        in   1   request one instruction while halted (run=0)
//  ins_valid       in   1   instruction word from InstructionMemory is valid
//  ctrl_regwen     in   1   decoded register write enable for current instruction
//  ctrl_is_branch  in   1   current instruction is branch/jump
//  has_branched    in   1   BranchControl resolved taken
//  alu_ready       in   1   ALU result valid
//  alu_start       out  1   one-cycle ALU start strobe
//  rf_we           out  1   register-file write strobe
//  pc_en           out  1   PC update strobe
//  pc_sel          out  1   PC source: 1 = branch target, 0 = PC+4
//  step_ack        out  1   one-cycle pulse when a stepped instruction retires
//  timeout_err     out  1   sticky ALU-timeout fault
//  state           out  2   IDLE=0, FETCH=1, EXEC=2, WB=3
//  retired_cnt     out  32  instructions retired, wraps 0xFFFFFFFF->0
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; all strobes 0; timeout_err=0; retired_cnt=0; step flag=0; EXEC counter=0.
//  State is registered. Strobes are decoded from state plus ctrl inputs; no strobe appears outside its state.
//  IDLE:
//   - No strobes.
//   - If timeout_err=1: stay in IDLE; run and step_req are ignored.
//   - Else if run=1: go to FETCH. run beats step_req when both are 1; no step_ack in that case.
//   - Else if step_req=1: set step flag, go to FETCH.
//  FETCH: hold until ins_valid=1, then go to EXEC with counter=1.
//  EXEC:
//   - alu_start=1 on the first EXEC cycle only. alu_ready is ignored in that cycle (stale-ready guard).
//   - From cycle 2 onward: alu_ready=1 -> WB. Otherwise the counter increments.
//   - Counter == ALU_TIMEOUT with alu_ready=0 -> set timeout_err, clear step flag, go to IDLE.
//     No rf_we/pc_en is issued for that instruction.
//   - alu_ready=1 exactly at the counter limit is accepted (ready wins).
//  WB (exactly 1 cycle):
//   - rf_we = ctrl_regwen; pc_en = 1; pc_sel = ctrl_is_branch & has_branched; retired_cnt += 1.
//   - Next: if step flag=1 -> step_ack=1, clear flag, go to IDLE.
//   - Else if run=1 -> FETCH; else -> IDLE.
//  run dropping mid-instruction: the instruction completes through WB, then IDLE.
//  step_req while not in IDLE, or while step flag is already set: ignored.
//  Minimum latency: 4 cycles per instruction (FETCH 1, EXEC 2, WB 1).
//  rst asserted in any state: immediate return to IDLE with all outputs at reset values.
//   The partial instruction is discarded; no write or PC update.
// TESTING
//  T1 reset: assert rst mid-EXEC with counter=5 -> next sample state=0, all strobes 0, retired_cnt=0, timeout_err=0.
//  T2 free-run: run=1, ins_valid=1, alu_ready=1, ctrl_regwen=1
//     -> rf_we and pc_en pulse once every 4 cycles; retired_cnt=5 after 20 cycles from FETCH.
//  T3 DIV: alu_ready rises on EXEC cycle 34 (ALU_TIMEOUT=40) -> WB the next cycle; timeout_err stays 0; retired_cnt+1.
//  T4 timeout: alu_ready held 0 -> after 40 EXEC cycles timeout_err=1, state=IDLE, pc_en never asserted.
//     A later run=1 keeps state=IDLE.
//  T5 step: run=0, one-cycle step_req -> exactly one alu_start and one pc_en; step_ack=1 for one cycle; retired_cnt+1; returns to IDLE.
//     step_req in the same cycle as run=1 -> no step_ack.
//  T6 branch/store: WB with ctrl_is_branch=1, has_branched=1 -> pc_sel=1, pc_en=1.
//     has_branched=0 -> pc_sel=0. ctrl_regwen=0 -> rf_we=0 while pc_en=1.

Source files
------------

// File: rtl/core_sequencer_if.sv
// Sequencer <-> datapath bundle: run/step control, decode and ALU status in,
// ALU/regfile/PC strobes, status and retired count out.
interface core_sequencer_if;
  logic        run;
  logic        step_req;
  logic        ins_valid;
  logic        ctrl_regwen;
  logic        ctrl_is_branch;
  logic        has_branched;
  logic        alu_ready;
  logic        alu_start;
  logic        rf_we;
  logic        pc_en;
  logic        pc_sel;
  logic        step_ack;
  logic        timeout_err;
  logic [1:0]  state;
  logic [31:0] retired_cnt;

  modport master (
    input  run, step_req, ins_valid,
    input  ctrl_regwen, ctrl_is_branch,
    input  has_branched, alu_ready,
    output alu_start, rf_we, pc_en, pc_sel,
    output step_ack, timeout_err,
    output state, retired_cnt
  );

  modport slave (
    output run, step_req, ins_valid,
    output ctrl_regwen, ctrl_is_branch,
    output has_branched, alu_ready,
    input  alu_start, rf_we, pc_en, pc_sel,
    input  step_ack, timeout_err,
    input  state, retired_cnt
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32IM sequencer: FETCH -> EXEC (wait ALU ready) -> WB.
// Ports: clk, rst (async high), bus (core_sequencer_if.master).
module core_sequencer #(
  parameter int ALU_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input logic              clk,
  input logic              rst,
  core_sequencer_if.master bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ALU_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             tmo_q, tmo_d;
  logic [31:0]      ret_q, ret_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      step_q <= 1'b0;
      tmo_q  <= 1'b0;
      ret_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      tmo_q  <= tmo_d;
      ret_q  <= ret_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    step_d = step_q;
    tmo_d  = tmo_q;
    ret_d  = ret_q;
    unique case (st_q)
      IDLE: begin
        if (!tmo_q) begin
          if (bus.run) begin
            st_d = FETCH;
          end else if (bus.step_req) begin
            step_d = 1'b1;
            st_d   = FETCH;
          end
        end
      end
      FETCH: begin
        if (bus.ins_valid) begin
          st_d  = EXEC;
          cnt_d = ONE;
        end
      end
      EXEC: begin
        // First cycle ignores a ready left over
        // from the previous operation.
        if (cnt_q == ONE) begin
          cnt_d = cnt_q + ONE;
        end else if (bus.alu_ready) begin
          st_d  = WB;
          cnt_d = '0;
        end else if (cnt_q == LIMIT) begin
          tmo_d  = 1'b1;
          step_d = 1'b0;
          st_d   = IDLE;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      WB: begin
        ret_d = ret_q + 32'd1;
        if (step_q) begin
          step_d = 1'b0;
          st_d   = IDLE;
        end else if (bus.run) begin
          st_d = FETCH;
        end else begin
          st_d = IDLE;
        end
      end
    endcase
  end

  assign bus.alu_start   = (st_q == EXEC) && (cnt_q == ONE);
  assign bus.rf_we       = (st_q == WB) && bus.ctrl_regwen;
  assign bus.pc_en       = (st_q == WB);
  assign bus.pc_sel      = (st_q == WB) && bus.ctrl_is_branch
                           && bus.has_branched;
  assign bus.step_ack    = (st_q == WB) && step_q;
  assign bus.timeout_err = tmo_q;
  assign bus.state       = st_q;
  assign bus.retired_cnt = ret_q;
endmodule
